countdown_ctrl: RTL and testbench
=================================

COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 125000000, SHALL set the clk cycles per count tick (1 s at 125 MHz); minimum 2.
REQ-002 clk  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  single-cycle pulse, already synchronised: start or resume the countdown.
REQ-005 pause  input  1  single-cycle pulse, already synchronised: freeze the countdown.
REQ-006 clear  input  1  single-cycle pulse, already synchronised: abort and reload the preset.
REQ-007 preset_tens  input  4  BCD tens digit of the start value.
REQ-008 preset_ones  input  4  BCD ones digit of the start value.
REQ-009 tens  output  4  current BCD tens digit, registered.
REQ-010 ones  output  4  current BCD ones digit, registered.
REQ-011 running  output  1  high while state is RUN.
REQ-012 done  output  1  high while state is DONE.
REQ-013 done_pulse  output  1  one-cycle strobe on entry to DONE.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN, PAUSE and DONE.
REQ-015 Command priority SHALL be clear > start > pause when pulses coincide.
REQ-016 Preset digits above 9 SHALL be clamped to 9 before use.
REQ-017 IDLE: tens/ones SHALL track the clamped preset every cycle.
REQ-018 IDLE + start with a nonzero preset -> RUN; a zero preset SHALL leave the FSM in IDLE.
REQ-019 The prescaler SHALL advance only in RUN, counting 0..TICK_DIV-1.
REQ-020 The prescaler SHALL issue a one-cycle tick at TICK_DIV-1 and wrap to 0.
REQ-021 The prescaler SHALL clear to 0 on entry to RUN from IDLE or DONE and on clear.
REQ-022 The prescaler SHALL hold its value in PAUSE, so a resumed count completes the remaining part of the second.
REQ-023 RUN, tick: the value SHALL decrement by one in BCD, registered at the same edge.
REQ-024 BCD decrement: ones 0 -> 9 with tens-1; otherwise ones-1.
REQ-025 RUN, tick with value 01: the value SHALL become 00, the FSM SHALL enter DONE, and done_pulse SHALL be high for the following cycle only.
REQ-026 RUN + pause -> PAUSE; a tick in the same cycle SHALL still decrement.
REQ-027 RUN + clear -> IDLE; the tick in that cycle SHALL be discarded.
REQ-028 PAUSE + start -> RUN, value unchanged.
REQ-029 PAUSE + clear -> IDLE.
REQ-030 PAUSE SHALL ignore pause.
REQ-031 DONE SHALL hold 00.
REQ-032 DONE + clear -> IDLE.
REQ-033 DONE + start SHALL reload the clamped preset and enter RUN; with a zero preset it SHALL enter IDLE.
REQ-034 RUN SHALL ignore start, and IDLE SHALL ignore pause.
REQ-035 The count SHALL never wrap below 00.

Reset
REQ-036 Reset assertion SHALL immediately force: state IDLE, prescaler 0, tens=0, ones=0, running=0, done=0, done_pulse=0.
REQ-037 Reset SHALL abort RUN or PAUSE mid-second with no done_pulse.
REQ-038 After reset release, tens/ones SHALL load the clamped preset on the first clk edge.

Structure
REQ-039 A shared package SHALL hold the state encodings (2-bit), the default TICK_DIV, and the BCD digit width.
REQ-040 The prescaler SHALL be a sub-module tick_gen with ports clk, rst_n, en, clr and tick, parameterised by TICK_DIV.
REQ-041 The FSM and the BCD counter SHALL reside in countdown_ctrl.

Verification (TICK_DIV=4)
REQ-042 Basic run: preset 12, start -> running=1; tens/ones 11 at 4 cycles after start; done_pulse exactly once, 48 cycles after start; done=1 and 00 held.
REQ-043 Borrow and clamp: preset 10, start -> 09 after the first tick; preset tens=0xA, ones=0xF in IDLE -> tens/ones show 99.
REQ-044 Pause on tick: preset 05, pause coincident with the first tick -> 04 held in PAUSE for 20 cycles; start -> 03 exactly 4 cycles later.
REQ-045 Priority: start+clear in RUN -> IDLE with the preset shown; start+pause in PAUSE -> RUN.
REQ-046 Reset mid-run: rst_n low at 2 cycles into a second -> all outputs 0 immediately, no done_pulse; after release, preset shown and state IDLE.
REQ-047 Zero preset: preset 00, start -> remains IDLE, running=0, no done_pulse.

Source files
------------

// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the countdown controller: state encoding, default
// prescaler ratio, BCD digit width and the digit clamp helper.
package countdown_ctrl_pkg;

  localparam int DEFAULT_TICK_DIV = 125000000;
  localparam int DIGIT_W          = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Non-BCD codes (A..F) saturate to 9 so the counter only ever holds valid digits.
  function automatic logic [DIGIT_W-1:0] clamp_bcd(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_W'(9)) ? DIGIT_W'(9) : d;
  endfunction

endpackage

// File: rtl/countdown_ctrl_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled and strobes tick on the last
// count; holds its value while disabled so a resumed second is completed.
module tick_gen #(
  parameter int TICK_DIV = 125000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Two-digit BCD countdown timer with start/pause/clear control and a
// TICK_DIV-cycle prescaler; all outputs are registered.
module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pause,
  input  logic               clear,
  input  logic [DIGIT_W-1:0] preset_tens,
  input  logic [DIGIT_W-1:0] preset_ones,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic               running,
  output logic               done,
  output logic               done_pulse
);

  state_t             state;
  logic [DIGIT_W-1:0] pre_tens;
  logic [DIGIT_W-1:0] pre_ones;
  logic               preset_zero;
  logic [DIGIT_W-1:0] dec_tens;
  logic [DIGIT_W-1:0] dec_ones;
  logic               last_step;
  logic               tick;
  logic               pre_en;
  logic               pre_clr;

  assign pre_tens    = clamp_bcd(preset_tens);
  assign pre_ones    = clamp_bcd(preset_ones);
  assign preset_zero = (pre_tens == '0) && (pre_ones == '0);

  // Holding the prescaler cleared in IDLE/DONE guarantees every fresh run
  // starts a full second; PAUSE keeps the partial count.
  assign pre_en  = (state == ST_RUN);
  assign pre_clr = clear || (state == ST_IDLE) || (state == ST_DONE);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  always_comb begin
    dec_tens = tens;
    dec_ones = ones - DIGIT_W'(1);
    if (ones == '0) begin
      dec_ones = DIGIT_W'(9);
      dec_tens = tens - DIGIT_W'(1);
    end
  end

  // Treating 00 like 01 keeps the count from ever wrapping below zero.
  assign last_step = (tens == '0) && (ones <= DIGIT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tens       <= '0;
      ones       <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          tens <= pre_tens;
          ones <= pre_ones;
          if (!clear && start && !preset_zero) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end

        ST_RUN: begin
          if (clear) begin
            state   <= ST_IDLE;
            tens    <= pre_tens;
            ones    <= pre_ones;
            running <= 1'b0;
          end else if (tick && last_step) begin
            state      <= ST_DONE;
            tens       <= '0;
            ones       <= '0;
            running    <= 1'b0;
            done       <= 1'b1;
            done_pulse <= 1'b1;
          end else begin
            if (tick) begin
              tens <= dec_tens;
              ones <= dec_ones;
            end
            if (pause) begin
              state   <= ST_PAUSE;
              running <= 1'b0;
            end
          end
        end

        ST_PAUSE: begin
          if (clear) begin
            state <= ST_IDLE;
            tens  <= pre_tens;
            ones  <= pre_ones;
          end else if (start) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end

        ST_DONE: begin
          tens <= '0;
          ones <= '0;
          if (clear) begin
            state <= ST_IDLE;
            tens  <= pre_tens;
            ones  <= pre_ones;
            done  <= 1'b0;
          end else if (start) begin
            tens <= pre_tens;
            ones <= pre_ones;
            done <= 1'b0;
            if (preset_zero) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
        end

        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl (TICK_DIV=4): directed scenarios plus random
// commands, checked every cycle against a decimal-value reference model.
module tb_countdown_ctrl;

  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] preset_tens = 4'd0;
  logic [3:0] preset_ones = 4'd0;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       done;
  logic       done_pulse;

  countdown_ctrl #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pause      (pause),
    .clear      (clear),
    .preset_tens(preset_tens),
    .preset_ones(preset_ones),
    .tens       (tens),
    .ones       (ones),
    .running    (running),
    .done       (done),
    .done_pulse (done_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int dp_count = 0;

  // Reference model: mode, remaining seconds as a plain integer, clk cycles
  // elapsed in the current second.
  int m_mode = M_IDLE;
  int m_val = 0;
  int m_phase = 0;
  bit m_pulse = 1'b0;

  function automatic int preset_value();
    int t, o;
    t = (preset_tens > 4'd9) ? 9 : int'(preset_tens);
    o = (preset_ones > 4'd9) ? 9 : int'(preset_ones);
    return t * 10 + o;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_val = 0; m_phase = 0; m_pulse = 1'b0;
  endtask

  task automatic model_step();
    int pv;
    bit second_over;
    pv = preset_value();
    m_pulse = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_mode)
      M_IDLE: begin
        m_val = pv;
        if (!clear && start && pv != 0) begin m_mode = M_RUN; m_phase = 0; end
      end
      M_RUN: begin
        if (clear) begin
          m_mode = M_IDLE; m_val = pv; m_phase = 0;
        end else begin
          second_over = (m_phase == TD - 1);
          m_phase = second_over ? 0 : m_phase + 1;
          if (second_over) m_val = m_val - 1;
          if (second_over && m_val <= 0) begin
            m_val = 0; m_mode = M_DONE; m_pulse = 1'b1;
          end else if (pause) begin
            m_mode = M_PAUSE;
          end
        end
      end
      M_PAUSE: begin
        if (clear) begin m_mode = M_IDLE; m_val = pv; m_phase = 0; end
        else if (start) m_mode = M_RUN;
      end
      default: begin
        m_val = 0;
        if (clear) begin
          m_mode = M_IDLE; m_val = pv;
        end else if (start) begin
          m_val = pv; m_phase = 0;
          m_mode = (pv != 0) ? M_RUN : M_IDLE;
        end
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".tens"}, 32'(tens), 32'(m_val / 10));
    check({tag, ".ones"}, 32'(ones), 32'(m_val % 10));
    check({tag, ".running"}, 32'(running), 32'(m_mode == M_RUN));
    check({tag, ".done"}, 32'(done), 32'(m_mode == M_DONE));
    check({tag, ".done_pulse"}, 32'(done_pulse), 32'(m_pulse));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    if (done_pulse === 1'b1) dp_count++;
    check_all(tag);
  endtask

  task automatic cmd(input bit s, input bit p, input bit c, input string tag);
    start = s; pause = p; clear = c;
    cycle(tag);
    start = 1'b0; pause = 1'b0; clear = 1'b0;
  endtask

  task automatic set_preset(input logic [3:0] t, input logic [3:0] o);
    preset_tens = t; preset_ones = o;
  endtask

  initial begin
    // Power-on reset
    set_preset(4'd1, 4'd2);
    #2;
    model_reset();
    check_all("reset");
    repeat (2) cycle("in_reset");
    rst_n = 1'b1;
    cycle("rst_release");
    check("release_tens", 32'(tens), 32'd1);
    check("release_ones", 32'(ones), 32'd2);

    // Basic run from 12
    dp_count = 0;
    cmd(1'b1, 1'b0, 1'b0, "start12");
    check("basic_running", 32'(running), 32'd1);
    repeat (4) cycle("basic");
    check("basic_11_tens", 32'(tens), 32'd1);
    check("basic_11_ones", 32'(ones), 32'd1);
    repeat (43) cycle("basic");
    check("basic_no_early_pulse", 32'(dp_count), 32'd0);
    cycle("basic_end");
    check("basic_pulse_at_48", 32'(done_pulse), 32'd1);
    repeat (5) cycle("basic_hold");
    check("basic_pulse_once", 32'(dp_count), 32'd1);
    check("basic_done", 32'(done), 32'd1);
    check("basic_hold00", 32'({tens, ones}), 32'h00);

    // Borrow and clamp
    cmd(1'b0, 1'b0, 1'b1, "clr_done");
    set_preset(4'd1, 4'd0);
    cycle("pre10");
    cmd(1'b1, 1'b0, 1'b0, "start10");
    repeat (4) cycle("borrow");
    check("borrow_09", 32'({tens, ones}), 32'h09);
    cmd(1'b0, 1'b0, 1'b1, "clr_borrow");
    set_preset(4'hA, 4'hF);
    cycle("clamp");
    check("clamp_99", 32'({tens, ones}), 32'h99);

    // Pause coincident with the first tick
    set_preset(4'd0, 4'd5);
    cycle("pre05");
    cmd(1'b1, 1'b0, 1'b0, "start05");
    repeat (3) cycle("pre_pause");
    cmd(1'b0, 1'b1, 1'b0, "pause_tick");
    check("pause_04", 32'({tens, ones}), 32'h04);
    check("pause_not_running", 32'(running), 32'd0);
    repeat (20) cycle("paused");
    check("pause_held_04", 32'({tens, ones}), 32'h04);
    cmd(1'b1, 1'b0, 1'b0, "resume");
    repeat (3) cycle("resumed");
    check("resume_still_04", 32'({tens, ones}), 32'h04);
    cycle("resumed");
    check("resume_03", 32'({tens, ones}), 32'h03);

    // Priority: clear beats start in RUN, start beats pause in PAUSE
    cmd(1'b1, 1'b0, 1'b1, "start_clear");
    check("prio_idle_preset", 32'({tens, ones}), 32'h05);
    check("prio_idle_running", 32'(running), 32'd0);
    cmd(1'b1, 1'b0, 1'b0, "restart");
    cmd(1'b0, 1'b1, 1'b0, "to_pause");
    cmd(1'b1, 1'b1, 1'b0, "start_pause");
    check("prio_run", 32'(running), 32'd1);

    // Reset two cycles into a second
    cmd(1'b0, 1'b0, 1'b1, "clr_before_rst");
    cmd(1'b1, 1'b0, 1'b0, "start_rst");
    repeat (2) cycle("before_rst");
    dp_count = 0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid");
    repeat (3) cycle("rst_mid_hold");
    rst_n = 1'b1;
    cycle("rst_mid_release");
    check("rst_mid_preset", 32'({tens, ones}), 32'h05);
    check("rst_mid_idle", 32'({running, done}), 32'd0);
    check("rst_mid_no_pulse", 32'(dp_count), 32'd0);

    // Zero preset
    set_preset(4'd0, 4'd0);
    cycle("pre00");
    dp_count = 0;
    cmd(1'b1, 1'b0, 1'b0, "start00");
    repeat (10) cycle("zero");
    check("zero_not_running", 32'(running), 32'd0);
    check("zero_no_pulse", 32'(dp_count), 32'd0);

    // Random commands and presets
    set_preset(4'd0, 4'd3);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0)
        set_preset(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      start = ($urandom_range(0, 14) == 0);
      pause = ($urandom_range(0, 11) == 0);
      clear = ($urandom_range(0, 59) == 0);
      cycle("rand");
    end
    start = 1'b0; pause = 1'b0; clear = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
